mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one single-port, variable-latency memory between the instruction-fetch requester (IF stage, read-only) and the data requester (MEM stage, read/write) of the 5-stage pipeline. The two requesters use a req/done handshake, and the memory uses a req/ack handshake. Data accesses normally take priority over fetches, and a streak counter bounds how long fetch can starve. The pipeline stalls a stage while that stage's req is high and its done has not yet pulsed.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MAX_DATA_STREAK, 4, maximum consecutive DM grants while if_req is pending (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched word, valid when if_done=1, held until the next IF read
- if_done  out  1  one-cycle completion pulse
- dm_req  in  1  data request, held until dm_done
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  write data
- dm_rdata  out  DATA_WIDTH  read data, updated only by DM reads
- dm_done  out  1  one-cycle completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one-cycle pulse
- owner  out  1  current/last grant: 0 = IF, 1 = DM

## Operation
- FSM states:
  - IDLE: no transaction in progress.
  - GRANT_IF: fetch transaction in flight.
  - GRANT_DM: data transaction in flight.
  - DONE: completion cycle.
- IDLE arbitration:
  - dm_req only → GRANT_DM.
  - if_req only → GRANT_IF.
  - Both requesting → GRANT_DM, unless streak == MAX_DATA_STREAK, in which case → GRANT_IF.
  - Neither → stay in IDLE.
- On grant, the request fields (addr, we, wdata) are latched into registers. mem_* outputs drive from these registers only, so they stay stable for the whole transaction regardless of requester inputs.
- mem_req=1 throughout GRANT_IF/GRANT_DM. mem_we = latched dm_we in GRANT_DM, 0 in GRANT_IF.
- mem_ack in a GRANT state:
  - read: capture mem_rdata into the winner's rdata register.
  - go to DONE; the winner's done pulses in the DONE cycle.
- DONE → IDLE unconditionally. No arbitration happens in DONE, so a requester has one cycle to drop or change its req.
- Streak counter:
  - Increments (saturating at MAX_DATA_STREAK) on each DM grant made while if_req=1.
  - Clears on every IF grant.
  - Clears on a DM grant with if_req=0.
- mem_ack in IDLE or DONE is ignored, with no state or data change.
- A requester dropping req mid-transaction does not abort it; the access completes and done still pulses.
- Reset (reset=0), asynchronous:
  - state IDLE, streak 0
  - mem_req, mem_we, if_done, dm_done = 0
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0
  - owner = 0
  - Any in-flight transaction is abandoned. An ack arriving after reset release is ignored (FSM is in IDLE).

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Request seen in IDLE at edge t:
  - mem_req rises after edge t.
  - mem_ack sampled at edge t+k (k≥1) → done high for the cycle after edge t+k.
  - IDLE again after edge t+k+1.
- Minimum turnaround is 3 cycles per access; peak throughput is one access per 3 cycles.
- if_done and dm_done are never high in the same cycle.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, GRANT_IF, GRANT_DM, DONE)
  - OWNER_IF=1'b0 and OWNER_DM=1'b1
- One sub-module is natural: arb_streak_counter, the saturating counter with clear (parameter MAX, ports clk/reset/inc/clr/sat).
- Everything else lives in mem_port_arbiter: FSM, request latch, rdata registers.

## Test plan
- IF read, ack delay 2: if_req=1, if_addr=0x40, mem_rdata=0x8C010004.
  → mem_req high 2 cycles with mem_addr=0x40 and mem_we=0; if_done 1 cycle with if_rdata=0x8C010004; dm_done=0 throughout.
- Both requesters in the same cycle, streak 0: dm_addr=0x100, if_addr=0x44.
  → DM granted first (owner=1); IF granted in the next IDLE; dm_done precedes if_done.
- Starvation, MAX_DATA_STREAK=4: dm_req and if_req held high continuously, ack delay 1.
  → grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- DM write after a read: DM read returns 0x12345678; then dm_we=1, dm_wdata=0xDEADBEEF, dm_addr=0x200.
  → mem_we=1 and mem_wdata=0xDEADBEEF while mem_req is high; dm_done pulses; dm_rdata stays 0x12345678.
- Reset mid-transaction: reset=0 during GRANT_DM with mem_req=1.
  → mem_req, dm_done and streak go to 0 immediately (no clock needed); a late mem_ack after release is ignored; the still-pending dm_req is re-granted 1 cycle after release.
- Spurious ack: mem_ack=1 in IDLE, mem_rdata=0xFFFFFFFF.
  → no done pulse; if_rdata and dm_rdata unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and owner codes for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_DM, DONE} arbState_t;
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;
endpackage

// File: rtl/arb_streak_counter.sv
// arb_streak_counter: saturating count of back-to-back data grants, flags when fetch must win
module arb_streak_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] count;
    // clear wins over increment; the count stops at MAX
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (clr) count <= '0;
        else if (inc && !sat) count <= count + 1'b1;
    assign sat = (count == W'(MAX));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF fetches and MEM-stage data accesses
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_done,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  owner
);
    arbState_t state, nextState;
    logic grantIf, grantDm, streakSat, latchedWe;

    // arbitration happens only in IDLE; data wins unless fetch has been starved too long
    always_comb begin
        nextState = state;
        grantDm   = 1'b0;
        grantIf   = 1'b0;
        case (state)
            IDLE: begin
                grantDm   = dm_req && !(if_req && streakSat);
                grantIf   = if_req && !grantDm;
                nextState = grantDm ? GRANT_DM : grantIf ? GRANT_IF : IDLE;
            end
            GRANT_IF, GRANT_DM: nextState = mem_ack ? DONE : state;
            default: nextState = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= nextState;

    arb_streak_counter #(.MAX(MAX_DATA_STREAK)) streakCounter (
        .clk  (clk),
        .reset(reset),
        .inc  (grantDm && if_req),
        .clr  (grantIf || (grantDm && !if_req)),
        .sat  (streakSat)
    );

    // latch the winning request so mem_* stay stable for the whole access
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            latchedWe <= 1'b0;
            owner     <= OWNER_IF;
        end else if (grantDm) begin
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            latchedWe <= dm_we;
            owner     <= OWNER_DM;
        end else if (grantIf) begin
            mem_addr  <= if_addr;
            latchedWe <= 1'b0;
            owner     <= OWNER_IF;
        end

    // capture read data for the winner; writes and acks outside a grant leave it untouched
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (mem_ack && state == GRANT_IF) begin
            if_rdata <= mem_rdata;
        end else if (mem_ack && state == GRANT_DM && !latchedWe) begin
            dm_rdata <= mem_rdata;
        end

    assign mem_req = (state == GRANT_IF) || (state == GRANT_DM);
    assign mem_we  = (state == GRANT_DM) && latchedWe;
    assign if_done = (state == DONE) && (owner == OWNER_IF);
    assign dm_done = (state == DONE) && (owner == OWNER_DM);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, starvation bound, writes, reset and stray acks
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, dm_done, mem_req, mem_we, owner;
    int          total = 0;
    int          bad = 0;
    logic [9:0]  grantOrder;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // runs one access from an IDLE cycle through to its DONE cycle, acking after `delay` grant cycles
    task automatic doAccess(input logic expDm, input int delay, input logic [31:0] rd,
                            input logic [31:0] expAddr, input logic expWe, input logic [31:0] expWdata);
        cyc();
        chk("grant_req", 32'(mem_req), 32'd1);
        chk("grant_owner", 32'(owner), 32'(expDm));
        chk("grant_addr", mem_addr, expAddr);
        chk("grant_we", 32'(mem_we), 32'(expWe));
        if (expWe) chk("grant_wdata", mem_wdata, expWdata);
        for (int i = 1; i < delay; i++) begin
            cyc();
            chk("hold_req", 32'(mem_req), 32'd1);
            chk("hold_addr", mem_addr, expAddr);
            chk("hold_done", 32'(if_done | dm_done), 32'd0);
        end
        mem_ack = 1'b1;
        mem_rdata = rd;
        cyc();
        mem_ack = 1'b0;
        chk("done_req", 32'(mem_req), 32'd0);
        chk("if_done", 32'(if_done), 32'(!expDm));
        chk("dm_done", 32'(dm_done), 32'(expDm));
        if (!expWe) chk("rdata", expDm ? dm_rdata : if_rdata, rd);
    endtask

    initial begin
        reset = 1'b0;
        {if_req, dm_req, dm_we, mem_ack} = '0;
        {if_addr, dm_addr, dm_wdata, mem_rdata} = '0;
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_dm_done", 32'(dm_done), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // IF read, ack after two grant cycles
        if_req = 1'b1;
        if_addr = 32'h40;
        doAccess(1'b0, 2, 32'h8C010004, 32'h40, 1'b0, 32'h0);
        if_req = 1'b0;
        cyc();

        // simultaneous requests: DM first, then IF
        dm_req = 1'b1;
        dm_addr = 32'h100;
        if_req = 1'b1;
        if_addr = 32'h44;
        doAccess(1'b1, 1, 32'h11112222, 32'h100, 1'b0, 32'h0);
        dm_req = 1'b0;
        cyc();
        doAccess(1'b0, 1, 32'h33334444, 32'h44, 1'b0, 32'h0);
        chk("t2_dm_rdata", dm_rdata, 32'h11112222);
        if_req = 1'b0;
        cyc();

        // starvation bound: four DM grants, then one IF, repeating
        dm_req = 1'b1;
        if_req = 1'b1;
        grantOrder = 10'b0111101111;
        for (int i = 0; i < 10; i++) begin
            doAccess(grantOrder[i], 1, 32'hA0000000 + 32'(i),
                     grantOrder[i] ? 32'h100 : 32'h44, 1'b0, 32'h0);
            cyc();
        end
        dm_req = 1'b0;
        if_req = 1'b0;

        // requester drops req and changes fields mid-access: access still completes unchanged
        dm_req = 1'b1;
        dm_addr = 32'h300;
        cyc();
        chk("drop_grant", 32'(mem_req), 32'd1);
        dm_req = 1'b0;
        dm_addr = 32'h555;
        dm_we = 1'b1;
        cyc();
        chk("drop_hold_req", 32'(mem_req), 32'd1);
        chk("drop_hold_addr", mem_addr, 32'h300);
        chk("drop_hold_we", 32'(mem_we), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'h0C0FFEE0;
        cyc();
        mem_ack = 1'b0;
        chk("drop_done", 32'(dm_done), 32'd1);
        chk("drop_rdata", dm_rdata, 32'h0C0FFEE0);
        cyc();
        chk("drop_idle_done", 32'(dm_done), 32'd0);
        chk("drop_idle_req", 32'(mem_req), 32'd0);
        dm_we = 1'b0;

        // DM read then DM write; the write must not disturb dm_rdata
        dm_req = 1'b1;
        dm_addr = 32'h1FC;
        doAccess(1'b1, 1, 32'h12345678, 32'h1FC, 1'b0, 32'h0);
        dm_we = 1'b1;
        dm_wdata = 32'hDEADBEEF;
        dm_addr = 32'h200;
        cyc();
        doAccess(1'b1, 2, 32'hFFFF0000, 32'h200, 1'b1, 32'hDEADBEEF);
        chk("wr_dm_rdata_kept", dm_rdata, 32'h12345678);
        chk("wr_if_rdata_kept", if_rdata, 32'hA0000009);
        dm_req = 1'b0;
        dm_we = 1'b0;
        cyc();

        // build a streak of three, reset during the fourth DM access
        dm_req = 1'b1;
        if_req = 1'b1;
        dm_addr = 32'h400;
        for (int i = 0; i < 3; i++) begin
            doAccess(1'b1, 1, 32'h0, 32'h400, 1'b0, 32'h0);
            cyc();
        end
        cyc();
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        chk("pre_rst_owner", 32'(owner), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_dm_done", 32'(dm_done), 32'd0);
        chk("async_rst_owner", 32'(owner), 32'd0);
        chk("async_rst_addr", mem_addr, 32'd0);
        chk("async_rst_dm_rdata", dm_rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h77777777;
        cyc();
        mem_ack = 1'b0;
        chk("rel_regrant_req", 32'(mem_req), 32'd1);
        chk("rel_regrant_owner", 32'(owner), 32'd1);
        chk("rel_regrant_addr", mem_addr, 32'h400);
        chk("rel_late_ack_done", 32'(dm_done), 32'd0);
        chk("rel_late_ack_rdata", dm_rdata, 32'd0);
        cyc();
        chk("rel_still_granted", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'h0BADF00D;
        cyc();
        mem_ack = 1'b0;
        chk("rel_done", 32'(dm_done), 32'd1);
        chk("rel_rdata", dm_rdata, 32'h0BADF00D);
        dm_req = 1'b0;
        if_req = 1'b0;
        cyc();

        // stray ack in IDLE
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        cyc();
        mem_ack = 1'b0;
        chk("stray_if_done", 32'(if_done), 32'd0);
        chk("stray_dm_done", 32'(dm_done), 32'd0);
        chk("stray_req", 32'(mem_req), 32'd0);
        cyc();
        chk("stray_if_done2", 32'(if_done), 32'd0);
        chk("stray_dm_done2", 32'(dm_done), 32'd0);
        chk("stray_if_rdata", if_rdata, 32'd0);
        chk("stray_dm_rdata", dm_rdata, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
